// File: rtl/zuss_data_mem_pkg.sv
// ZUSS data memory shared types.
// Word/byte-lane widths for the load/store path.
package zuss_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [BYTE_LANES-1:0] be_t;

endpackage

// File: rtl/zuss_data_mem_if.sv
// ZUSS data memory access bus.
// Core memory stage drives master; memory is slave.
interface zuss_data_mem_if;
  import zuss_mem_pkg::*;

  be_t         we;
  logic [31:0] addr;
  word_t       data;
  word_t       out;

  modport master (
    output we,
    output addr,
    output data,
    input  out
  );

  modport slave (
    input  we,
    input  addr,
    input  data,
    output out
  );

endinterface

// File: rtl/zuss_dmem_byte_merge.sv
// ZUSS data memory byte-lane merge.
// Enabled lanes take new data, others keep the old word.
module zuss_dmem_byte_merge
  import zuss_mem_pkg::*;
(
  input  word_t old_i,
  input  word_t new_i,
  input  be_t   be_i,
  output word_t merged_o
);

  for (genvar i = 0; i < BYTE_LANES; i++) begin : g_lane
    assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8]
                                        : old_i[8*i +: 8];
  end

endmodule

// File: rtl/zuss_data_mem.sv
// ZUSS single-port data memory, byte enables,
// registered write-first read, zero-cleared on reset.
module zuss_data_mem
  import zuss_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  zuss_data_mem_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  word_t mem_q [DEPTH];
  word_t out_q;
  word_t out_d;
  idx_t  idx;

  // Byte offset and bits above the index are dropped; addresses wrap.
  assign idx = bus.addr[DEPTH_LOG2+1:2];

  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:DEPTH_LOG2+2],
                         bus.addr[1:0]};

  zuss_dmem_byte_merge u_merge (
    .old_i    (mem_q[idx]),
    .new_i    (bus.data),
    .be_i     (bus.we),
    .merged_o (out_d)
  );

  // Merged word feeds both the array and the read register,
  // which gives write-first forwarding for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      out_q <= '0;
    end else begin
      mem_q[idx] <= out_d;
      out_q      <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_zuss_data_mem.sv
// Directed bench for zuss_data_mem.
// Vector table plus async-reset and mid-cycle corner sequences.
module tb_zuss_data_mem;
  import zuss_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  zuss_data_mem_if bus ();

  zuss_data_mem #(.DEPTH_LOG2(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    be_t         we;
    logic [31:0] addr;
    word_t       data;
    word_t       exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input word_t exp);
    n_total++;
    if (bus.out === exp) n_pass++;
    else $display("FAIL %s: out=%h expected=%h", name, bus.out, exp);
  endtask

  task automatic access(input be_t we, input logic [31:0] addr,
                        input word_t data);
    @(negedge clk);
    bus.we   = we;
    bus.addr = addr;
    bus.data = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0]  = '{4'b0000, 32'd500,        32'h0,        32'h00000000};
    vecs[1]  = '{4'b0001, 32'd500,        32'd250,      32'h000000FA};
    vecs[2]  = '{4'b0001, 32'd500,        32'd100,      32'h00000064};
    vecs[3]  = '{4'b0101, 32'd1000,       32'h001F0025, 32'h001F0025};
    vecs[4]  = '{4'b0011, 32'd1000,       32'd512,      32'h001F0200};
    vecs[5]  = '{4'b0000, 32'd1000,       32'hFFFFFFFF, 32'h001F0200};
    vecs[6]  = '{4'b1111, 32'd1000,       32'hDEADBEEF, 32'hDEADBEEF};
    vecs[7]  = '{4'b0000, 32'd1002,       32'h0,        32'hDEADBEEF};
    vecs[8]  = '{4'b0000, 32'd5096,       32'h0,        32'hDEADBEEF};
    vecs[9]  = '{4'b0000, 32'd500,        32'h0,        32'h00000064};
    vecs[10] = '{4'b1010, 32'd4596,       32'h11223344, 32'h11003364};
    vecs[11] = '{4'b0000, 32'd500,        32'h0,        32'h11003364};

    bus.we   = '0;
    bus.addr = '0;
    bus.data = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset pulse between edges clears out immediately
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'h0);
    #1;
    rst_n = 1'b1;

    access(4'b0000, 32'd500, 32'h0);
    check("post_rst_500", 32'h0);
    access(4'b0000, 32'd1000, 32'h0);
    check("post_rst_1000", 32'h0);

    // First edge after a reset release is a normal write
    @(negedge clk);
    rst_n    = 1'b0;
    bus.we   = 4'b1111;
    bus.addr = 32'd8;
    bus.data = 32'hCAFE0000;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_wr", 32'hCAFE0000);

    // Write request withdrawn before the edge must not land
    bus.we   = 4'b1111;
    bus.addr = 32'd12;
    bus.data = 32'h55555555;
    #2;
    bus.we   = 4'b0000;
    @(posedge clk);
    #1;
    check("midcycle_noeff", 32'h0);
    access(4'b0000, 32'd8, 32'h0);
    check("readback_8", 32'hCAFE0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
